// File: rtl/mem_stage.sv
// mem_stage: consumer end of the EX/MEM pipeline register.
//
// Unpacks the execute-stage word, performs the load or store on a handshaked
// data-memory port, and packs the MEM/WB register. memStall freezes EX/MEM and
// upstream stages while an access is in flight.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   defined   : an ACCESS watchdog aborts after TIMEOUT cycles without memAck,
//               sets the sticky memErr and turns the instruction into a bubble.
//   undefined : no watchdog, memErr tied 0, ACCESS waits indefinitely.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   en         MEM/WB load enable (low = downstream stall)
//   flush      synchronous bubble insert
//   bufferIn   EX/MEM register contents (IW bits)
//   memRData   memory read data
//   memAck     memory completion strobe
//   memReq     memory request
//   memWe      1 = store
//   memAddr    word address
//   memWData   store data
//   memStall   freeze EX/MEM and upstream stages
//   memErr     sticky timeout error
//   aluOutFwd  forwarding value from bufferIn (aluResult)
//   resultFwd  forwarding value from bufferOut (readData or aluResult)
//   bufferOut  MEM/WB register {regWrite, memToReg, Rc, aluResult, readData}
module mem_stage #(
    parameter int N       = 24,
    parameter int IW      = 2*N+24,
    parameter int OW      = 2*N+6,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          flush,
    input  logic [IW-1:0] bufferIn,
    input  logic [N-1:0]  memRData,
    input  logic          memAck,
    output logic          memReq,
    output logic          memWe,
    output logic [N-1:0]  memAddr,
    output logic [N-1:0]  memWData,
    output logic          memStall,
    output logic          memErr,
    output logic [N-1:0]  aluOutFwd,
    output logic [N-1:0]  resultFwd,
    output logic [OW-1:0] bufferOut
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } stateT;

    stateT state;

    // EX/MEM field unpack
    logic [1:0]   opType;
    logic [3:0]   opCode;
    logic [N-1:0] aluResult;
    logic         zero;
    logic         neg;
    logic         branchFlag;
    logic         memWrite;
    logic         memToReg;
    logic         regWrite;
    logic [3:0]   ra;
    logic [3:0]   rb;
    logic [3:0]   rc;
    logic [N-1:0] rd3;

    assign opType     = bufferIn[2*N+23:2*N+22];
    assign opCode     = bufferIn[2*N+21:2*N+18];
    assign aluResult  = bufferIn[2*N+17:N+18];
    assign zero       = bufferIn[N+17];
    assign neg        = bufferIn[N+16];
    assign branchFlag = bufferIn[N+15];
    assign memWrite   = bufferIn[N+14];
    assign memToReg   = bufferIn[N+13];
    assign regWrite   = bufferIn[N+12];
    assign ra         = bufferIn[N+11:N+8];
    assign rb         = bufferIn[N+7:N+4];
    assign rc         = bufferIn[N+3:N];
    assign rd3        = bufferIn[N-1:0];

    // Fields carried by this stage that MEM itself does not consume.
    logic unusedFields;
    assign unusedFields = ^{opType, opCode, zero, neg, branchFlag, ra, rb};

    logic         memOp;
    logic [N-1:0] readData;
    logic         flushPend;

    assign memOp = memWrite | memToReg;

    // Forwarding paths
    logic         outMemToReg;
    logic [N-1:0] outAlu;
    logic [N-1:0] outRead;

    assign outMemToReg = bufferOut[OW-2];
    assign outAlu      = bufferOut[2*N-1:N];
    assign outRead     = bufferOut[N-1:0];
    assign resultFwd   = outMemToReg ? outRead : outAlu;
    assign aluOutFwd   = rst ? aluResult : '0;

    // Stall is raised combinationally in IDLE so EX/MEM freezes on the very
    // edge that launches the access; DONE releases it so EX/MEM advances on
    // the same edge that writes MEM/WB.
    assign memStall = rst & ((state == ACCESS) | ((state == IDLE) & memOp));

`ifdef MEM_TIMEOUT_EN
    logic [CW-1:0] cnt;
`else
    logic [CW-1:0] unusedTimeout;
    assign unusedTimeout = '0;
    assign memErr        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            memReq    <= 1'b0;
            memWe     <= 1'b0;
            memAddr   <= '0;
            memWData  <= '0;
            readData  <= '0;
            flushPend <= 1'b0;
            bufferOut <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt       <= '0;
            memErr    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (flush) begin
                        bufferOut <= '0;
                    end else if (memOp) begin
                        state    <= ACCESS;
                        memReq   <= 1'b1;
                        memWe    <= memWrite;
                        memAddr  <= aluResult;
                        memWData <= rd3;
`ifdef MEM_TIMEOUT_EN
                        cnt      <= '0;
`endif
                        if (en) bufferOut <= '0;
                    end else if (en) begin
                        bufferOut <= {regWrite, memToReg, rc, aluResult, {N{1'b0}}};
                    end
                end

                ACCESS: begin
                    // A flush cannot cancel a started access; it is remembered
                    // and applied when the result would have been written.
                    if (flush) flushPend <= 1'b1;
                    if (en) bufferOut <= '0;
                    if (memAck) begin
                        readData <= memWe ? '0 : memRData;
                        memReq   <= 1'b0;
                        memWe    <= 1'b0;
                        state    <= DONE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (cnt == CW'(TIMEOUT - 1)) begin
                        readData  <= '0;
                        memReq    <= 1'b0;
                        memWe     <= 1'b0;
                        memErr    <= 1'b1;
                        flushPend <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end

                DONE: begin
                    if (flush) begin
                        bufferOut <= '0;
                        flushPend <= 1'b0;
                        state     <= IDLE;
                    end else if (en) begin
                        bufferOut <= flushPend ? '0
                                   : {regWrite, memToReg, rc, aluResult, readData};
                        flushPend <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed test-plan steps followed by
// randomized instructions, each compared with a transaction-level model of
// the MEM stage (what MEM/WB should hold after each instruction retires).
module tb_mem_stage;

    localparam int N  = 24;
    localparam int IW = 2*N+24;
    localparam int OW = 2*N+6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          flush = 1'b0;
    logic [IW-1:0] bufferIn = '0;
    logic [N-1:0]  memRData = '0;
    logic          memAck = 1'b0;
    logic          memReq;
    logic          memWe;
    logic [N-1:0]  memAddr;
    logic [N-1:0]  memWData;
    logic          memStall;
    logic          memErr;
    logic [N-1:0]  aluOutFwd;
    logic [N-1:0]  resultFwd;
    logic [OW-1:0] bufferOut;

    int checks   = 0;
    int failures = 0;

    // Model of what MEM/WB currently holds.
    logic [OW-1:0] modelWb = '0;

    always #5 clk = ~clk;

    mem_stage #(.N(N), .IW(IW), .OW(OW), .TIMEOUT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .bufferIn  (bufferIn),
        .memRData  (memRData),
        .memAck    (memAck),
        .memReq    (memReq),
        .memWe     (memWe),
        .memAddr   (memAddr),
        .memWData  (memWData),
        .memStall  (memStall),
        .memErr    (memErr),
        .aluOutFwd (aluOutFwd),
        .resultFwd (resultFwd),
        .bufferOut (bufferOut)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // EX/MEM word; fields MEM ignores get random values.
    function automatic logic [IW-1:0] mkIn(input logic mw, input logic mtr, input logic rw,
                                           input logic [3:0] rc, input logic [N-1:0] alu,
                                           input logic [N-1:0] rd3);
        logic [1:0] opT = 2'($urandom);
        logic [3:0] opC = 4'($urandom);
        logic [2:0] flg = 3'($urandom);
        logic [3:0] ra  = 4'($urandom);
        logic [3:0] rb  = 4'($urandom);
        return {opT, opC, alu, flg, mw, mtr, rw, ra, rb, rc, rd3};
    endfunction

    function automatic logic [OW-1:0] wbWord(input logic rw, input logic mtr, input logic [3:0] rc,
                                             input logic [N-1:0] alu, input logic [N-1:0] rdat);
        return {rw, mtr, rc, alu, rdat};
    endfunction

    // Single-cycle ALU instruction.
    task automatic doAlu(input logic rw, input logic [3:0] rc, input logic [N-1:0] alu,
                         input logic fl, input logic enV);
        bufferIn = mkIn(1'b0, 1'b0, rw, rc, alu, N'($urandom));
        en       = enV;
        flush    = fl;
        memAck   = 1'b0;
        #1;
        chk("alu_stall", memStall, 0);
        chk("alu_fwd", aluOutFwd, alu);
        step();
        flush = 1'b0;
        if (fl) modelWb = '0;
        else if (enV) modelWb = wbWord(rw, 1'b0, rc, alu, '0);
        chk("alu_out", bufferOut, modelWb);
        chk("alu_resfwd", resultFwd, modelWb[OW-2] ? modelWb[N-1:0] : modelWb[2*N-1:N]);
        chk("alu_req", memReq, 0);
    endtask

    // Load or store. flushMode: 0 none, 1 during ACCESS, 2 on the DONE edge.
    task automatic doMem(input logic isStore, input logic mtr, input logic rw, input logic [3:0] rc,
                         input logic [N-1:0] alu, input logic [N-1:0] rd3, input logic [N-1:0] rdat,
                         input int ackDelay, input int holdDone, input int flushMode);
        logic mtrBit;
        logic [N-1:0] rEff;
        int stalls;
        mtrBit   = isStore ? mtr : 1'b1;
        rEff     = isStore ? '0 : rdat;
        bufferIn = mkIn(isStore, mtrBit, rw, rc, alu, rd3);
        en       = 1'b1;
        flush    = 1'b0;
        memAck   = 1'b0;
        #1;
        stalls = 0;
        chk("idle_stall", memStall, 1);
        if (memStall) stalls++;
        step();
        for (int i = 0; i <= ackDelay; i++) begin
            chk("acc_req", memReq, 1);
            chk("acc_we", memWe, isStore);
            chk("acc_addr", memAddr, alu);
            chk("acc_wdata", memWData, rd3);
            chk("acc_bubble", bufferOut, 0);
            if (memStall) stalls++;
            memAck   = (i == ackDelay);
            memRData = memAck ? rdat : N'($urandom);
            flush    = (flushMode == 1) && (i == ackDelay / 2);
            step();
        end
        memAck   = 1'b0;
        flush    = 1'b0;
        memRData = N'($urandom);
        chk("done_req", memReq, 0);
        chk("done_we", memWe, 0);
        chk("done_stall", memStall, 0);
        if (memStall) stalls++;
        chk("stall_len", stalls, ackDelay + 2);
        en = 1'b0;
        for (int h = 0; h < holdDone; h++) begin
            memAck   = 1'b1;
            memRData = N'($urandom);
            step();
            chk("hold_out", bufferOut, 0);
            chk("hold_stall", memStall, 0);
            chk("hold_req", memReq, 0);
        end
        memAck = 1'b0;
        en     = 1'b1;
        flush  = (flushMode == 2);
        step();
        flush   = 1'b0;
        modelWb = (flushMode != 0) ? '0 : wbWord(rw, mtrBit, rc, alu, rEff);
        chk("mem_out", bufferOut, modelWb);
        chk("mem_resfwd", resultFwd, (flushMode != 0) ? '0 : (mtrBit ? rEff : alu));
    endtask

    logic [3:0]   rRc;
    logic [N-1:0] rAlu;
    logic [N-1:0] rRd3;
    logic [N-1:0] rDat;
    int           kind;

    initial begin
        // Reset state
        #3;
        chk("rst_out", bufferOut, 0);
        chk("rst_req", memReq, 0);
        chk("rst_stall", memStall, 0);
        chk("rst_err", memErr, 0);
        chk("rst_resfwd", resultFwd, 0);
        step();
        rst = 1'b1;
        step();

        // Directed test-plan steps
        doAlu(1'b1, 4'd5, 24'h000123, 1'b0, 1'b1);
        chk("tp1_word", bufferOut, {1'b1, 1'b0, 4'd5, 24'h000123, 24'h0});
        doMem(1'b0, 1'b1, 1'b1, 4'd7, 24'h000040, 24'h0, 24'hABCDEF, 0, 0, 0);
        chk("tp2_fwd", resultFwd, 24'hABCDEF);
        doMem(1'b1, 1'b0, 1'b0, 4'd3, 24'h000010, 24'h55AA55, 24'h123456, 4, 0, 0);
        chk("tp3_rw", bufferOut[OW-1], 0);
        doMem(1'b0, 1'b1, 1'b1, 4'd9, 24'h000200, 24'h0, 24'h0F0F0F, 1, 3, 0);
        doMem(1'b1, 1'b0, 1'b0, 4'd2, 24'h000300, 24'h777777, 24'h0, 3, 0, 1);
        doAlu(1'b1, 4'd4, 24'h00BEEF, 1'b0, 1'b1);
        doMem(1'b0, 1'b1, 1'b1, 4'd1, 24'h000044, 24'h0, 24'h999999, 0, 0, 1);
        doMem(1'b0, 1'b1, 1'b1, 4'd6, 24'h000048, 24'h0, 24'h888888, 2, 1, 2);
        doMem(1'b1, 1'b1, 1'b1, 4'd8, 24'h00004C, 24'hC0FFEE, 24'hFFFFFF, 1, 0, 0);
        doAlu(1'b1, 4'd11, 24'h000777, 1'b0, 1'b1);
        doAlu(1'b1, 4'd12, 24'h000888, 1'b0, 1'b0);
        doAlu(1'b1, 4'd13, 24'h000999, 1'b1, 1'b1);

        // Randomized instruction stream
        for (int k = 0; k < 25; k++) begin
            kind = int'($urandom_range(0, 2));
            rRc  = 4'($urandom);
            rAlu = N'($urandom);
            rRd3 = N'($urandom);
            rDat = N'($urandom);
            case (kind)
                0: doAlu(1'($urandom), rRc, rAlu, ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) != 0));
                1: doMem(1'b0, 1'b1, 1'($urandom), rRc, rAlu, rRd3, rDat, int'($urandom_range(0, 4)),
                         int'($urandom_range(0, 2)), ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0);
                default: doMem(1'b1, 1'($urandom), 1'($urandom), rRc, rAlu, rRd3, rDat, int'($urandom_range(0, 4)),
                               int'($urandom_range(0, 2)), ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0);
            endcase
        end

        // Reset during ACCESS; MEM/WB holds an ALU result beforehand
        doAlu(1'b1, 4'd14, 24'h0A0A0A, 1'b0, 1'b1);
        bufferIn = mkIn(1'b0, 1'b1, 1'b1, 4'd3, 24'h000123, 24'h0);
        en = 1'b0;
        step();
        chk("mid_req", memReq, 1);
        chk("mid_hold", bufferOut, modelWb);
        #2 rst = 1'b0;
        #1;
        chk("arst_req", memReq, 0);
        chk("arst_stall", memStall, 0);
        chk("arst_out", bufferOut, 0);
        chk("arst_addr", memAddr, 0);
        chk("arst_fwd", resultFwd, 0);
        bufferIn = '0;
        modelWb  = '0;
        step();
        rst = 1'b1;
        for (int r = 0; r < 3; r++) begin
            step();
            chk("noreissue", memReq, 0);
        end
        chk("err_default", memErr, 0);

`ifdef MEM_TIMEOUT_EN
        // Watchdog: no memAck, TIMEOUT=8
        doAlu(1'b1, 4'd15, 24'h0B0B0B, 1'b0, 1'b1);
        bufferIn = mkIn(1'b0, 1'b1, 1'b1, 4'd2, 24'h000050, 24'h0);
        en = 1'b0;
        memAck = 1'b0;
        step();
        for (int c = 0; c < 8; c++) begin
            chk("to_req", memReq, 1);
            chk("to_err_low", memErr, 0);
            step();
        end
        chk("to_err", memErr, 1);
        chk("to_req_drop", memReq, 0);
        chk("to_stall", memStall, 0);
        chk("to_hold", bufferOut, modelWb);
        en = 1'b1;
        step();
        chk("to_bubble", bufferOut, 0);
        bufferIn = '0;
        step();
        chk("to_sticky", memErr, 1);
        rst = 1'b0;
        #1;
        chk("to_clear", memErr, 0);
        step();
        rst = 1'b1;
`endif

        bufferIn = '0;
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
